// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   div_state_t : controller states (IDLE, BUSY, DONE)
//   CNT_W(n)    : width of the bit counter that walks an n-bit operand
// ----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The counter runs from n-1 down to 0.
    // It is kept at least one bit wide so that tiny widths still elaborate.
    function automatic int CNT_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_sub_row.sv
// ----------------------------------------------------------------------------
// div_sub_row
// A single borrow-ripple subtract row with a restore mux. The divider core
// reuses this one row on every iteration.
// Parameters:
//   W          row width (operand width + 1)
// Ports:
//   minuend    in   W  shifted partial remainder
//   subtrahend in   W  zero-extended divisor
//   diff       out  W  minuend - subtrahend (modulo 2^W)
//   borrow     out  1  set when subtrahend > minuend
//   next       out  W  restored (minuend) or subtracted (diff) partial remainder
// ----------------------------------------------------------------------------
module div_sub_row #(
    parameter int W = 9
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic [W-1:0] next
);

    logic [W:0] bor;

    // Ripple the borrow from the LSB upward, one full subtractor per bit.
    // This is the same cell the multiplier array uses, run in reverse.
    always_comb begin
        bor    = '0;
        diff   = '0;
        bor[0] = 1'b0;
        for (int i = 0; i < W; i++) begin
            diff[i]  = minuend[i] ^ subtrahend[i] ^ bor[i];
            bor[i+1] = (~minuend[i] & subtrahend[i]) |
                       (~(minuend[i] ^ subtrahend[i]) & bor[i]);
        end
    end

    // A borrow out means the divisor did not fit.
    // In that case the shifted value is kept unchanged (the restore step).
    assign borrow = bor[W];
    assign next   = borrow ? minuend : diff;

endmodule

// File: rtl/seq_array_divider.sv
// ----------------------------------------------------------------------------
// seq_array_divider
// Sequential restoring divider that produces one quotient bit per cycle. It
// uses the valid/ready handshake shared with the array multiplier.
// Parameters:
//   N            operand width (N >= 2)
// Ports:
//   clk          in   1  rising-edge clock
//   rst_n        in   1  asynchronous active-low reset
//   in_valid     in   1  operands present
//   in_ready     out  1  high only while idle
//   dividend     in   N  numerator
//   divisor      in   N  denominator
//   out_valid    out  1  result present (held until out_ready)
//   out_ready    in   1  consumer takes result
//   quotient     out  N  dividend / divisor ('1 on divide by zero)
//   remainder    out  N  dividend % divisor (dividend on divide by zero)
//   div_by_zero  out  1  divisor was zero for the current result
// Configuration:
//   DIV_SIGNED_EN  when defined, operands are two's complement.
//                  Magnitudes go through the unsigned core.
//                  Signs are applied in one extra BUSY cycle, so latency is N+2.
// ----------------------------------------------------------------------------
module seq_array_divider
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int KW = CNT_W(N);
    localparam logic [KW-1:0] K_START = KW'(N - 1);

    div_state_t     state;
    logic [KW-1:0]  k;
    logic [N:0]     p;
    logic [N-1:0]   dvd;
    logic [N-1:0]   dsr;
    logic [N-1:0]   quo;

    logic [N:0]     row_in;
    logic [N:0]     row_diff;
    logic           row_borrow;
    logic [N:0]     row_next;
    logic           unused_bits;

    logic [N-1:0]   dvd_load;
    logic [N-1:0]   dsr_load;

`ifdef DIV_SIGNED_EN
    logic           neg_q;
    logic           neg_r;
    logic           fix;

    // The core only ever sees magnitudes.
    // The magnitude of MIN is 2^(N-1), which still fits in N unsigned bits.
    assign dvd_load = dividend[N-1] ? -dividend : dividend;
    assign dsr_load = divisor[N-1]  ? -divisor  : divisor;
`else
    assign dvd_load = dividend;
    assign dsr_load = divisor;
`endif

    // Bring the next dividend bit into the bottom of the partial remainder.
    // Then try to take the divisor out of it.
    assign row_in = {p[N-1:0], dvd[k]};

    div_sub_row #(.W(N + 1)) u_row (
        .minuend    (row_in),
        .subtrahend ({1'b0, dsr}),
        .diff       (row_diff),
        .borrow     (row_borrow),
        .next       (row_next)
    );

    // The raw difference is only needed inside the row's restore mux.
    // The top bit of P is always zero once a step has finished, because the
    // remainder is then smaller than the divisor.
    assign unused_bits = ^{row_diff, p[N]};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Controller and datapath registers.
    // The visible result registers are written only on entry to DONE.
    // A divide by zero skips the iteration and goes straight to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= '0;
            p           <= '0;
            dvd         <= '0;
            dsr         <= '0;
            quo         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            fix         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            dvd   <= dvd_load;
                            dsr   <= dsr_load;
                            p     <= '0;
                            quo   <= '0;
                            k     <= K_START;
`ifdef DIV_SIGNED_EN
                            neg_q <= dividend[N-1] ^ divisor[N-1];
                            neg_r <= dividend[N-1];
                            fix   <= 1'b0;
`endif
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
`ifdef DIV_SIGNED_EN
                    if (fix) begin
                        // Extra cycle: restore the signs.
                        // The quotient truncates toward zero; the remainder follows the dividend.
                        quotient  <= neg_q ? -quo : quo;
                        remainder <= neg_r ? -p[N-1:0] : p[N-1:0];
                        fix       <= 1'b0;
                        state     <= DONE;
                    end else begin
                        p      <= row_next;
                        quo[k] <= ~row_borrow;
                        if (k == '0) begin
                            fix <= 1'b1;
                        end else begin
                            k <= k - 1'b1;
                        end
                    end
`else
                    p      <= row_next;
                    quo[k] <= ~row_borrow;
                    if (k == '0) begin
                        quotient  <= {quo[N-1:1], ~row_borrow};
                        remainder <= row_next[N-1:0];
                        state     <= DONE;
                    end else begin
                        k <= k - 1'b1;
                    end
`endif
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_array_divider
// Directed and randomised checks of seq_array_divider with N = 8.
// Expected results come from hand-computed tables and from a small model of
// the / and % operators. Define DIV_SIGNED_EN to check the signed build.
// ----------------------------------------------------------------------------
module tb_seq_array_divider;

`ifdef DIV_SIGNED_EN
    localparam int EXP_LAT = 10;
`else
    localparam int EXP_LAT = 9;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int assert_count = 0;
    int fail_count   = 0;

    seq_array_divider #(.N(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock. The bench drives inputs and samples outputs 1ns after each rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour: {quotient, remainder, div_by_zero}
    function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        int qq;
        int rr;
        sa = $signed(a);
        sb = $signed(b);
        qq = 0;
        rr = 0;
        if (b == 8'd0) return {8'hFF, a, 1'b1};
`ifdef DIV_SIGNED_EN
        if (sa == -128 && sb == -1) return {8'h80, 8'h00, 1'b0};
        qq = sa / sb;
        rr = sa % sb;
        return {qq[7:0], rr[7:0], 1'b0};
`else
        return {a / b, a % b, 1'b0};
`endif
    endfunction

    // Offer one operation (the block must be idle).
    // Then wait, with a bound, for the result.
    // lat counts cycles from the accept edge (accept edge = 1).
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output bit ok);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = out_valid;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 8'd0;
        divisor   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        assert_count++;
        if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL reset_state: got ov=%b ir=%b q=%h r=%h dbz=%b, expected ov=0 ir=1 q=00 r=00 dbz=0",
                     out_valid, in_ready, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        assert_count++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL post_reset_idle: got ir=%b ov=%b, expected ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [7:0] vec [4][4];
        int lat;
        bit ok;
        vec[0] = '{8'd100, 8'd7,   8'd14,  8'd2};
        vec[1] = '{8'd255, 8'd1,   8'd255, 8'd0};
        vec[2] = '{8'd3,   8'd200, 8'd0,   8'd3};
        vec[3] = '{8'd0,   8'd5,   8'd0,   8'd0};
        for (int i = 0; i < 4; i++) begin
            do_op(vec[i][0], vec[i][1], lat, ok);
            assert_count++;
            if (!ok || lat != EXP_LAT) begin
                fail_count++;
                $display("[TB] FAIL basic_latency %0d/%0d: got valid=%b after %0d cycles, expected valid after %0d",
                         vec[i][0], vec[i][1], ok, lat, EXP_LAT);
            end
            assert_count++;
            if ({quotient, remainder, div_by_zero} !== {vec[i][2], vec[i][3], 1'b0}) begin
                fail_count++;
                $display("[TB] FAIL basic_result %0d/%0d: got q=%0d r=%0d dbz=%b, expected q=%0d r=%0d dbz=0",
                         vec[i][0], vec[i][1], quotient, remainder, div_by_zero, vec[i][2], vec[i][3]);
            end
            release_result();
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        bit ok;
        do_op(8'd5, 8'd0, lat, ok);
        assert_count++;
        if (!ok || lat != 1) begin
            fail_count++;
            $display("[TB] FAIL dbz_latency: got valid=%b after %0d cycles, expected valid after 1", ok, lat);
        end
        assert_count++;
        if ({quotient, remainder, div_by_zero} !== {8'hFF, 8'd5, 1'b1}) begin
            fail_count++;
            $display("[TB] FAIL dbz_result: got q=%h r=%h dbz=%b, expected q=ff r=05 dbz=1",
                     quotient, remainder, div_by_zero);
        end
        release_result();
        // Accepting a new operation clears the flag immediately.
        // The quotient and remainder keep their old values until the new result is ready.
        dividend = 8'd9;
        divisor  = 8'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        assert_count++;
        if ({in_ready, quotient, remainder, div_by_zero} !== {1'b0, 8'hFF, 8'd5, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL dbz_clear_hold: got ir=%b q=%h r=%h dbz=%b, expected ir=0 q=ff r=05 dbz=0",
                     in_ready, quotient, remainder, div_by_zero);
        end
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        assert_count++;
        if (!out_valid || {quotient, remainder, div_by_zero} !== {8'd3, 8'd0, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL dbz_followup: got ov=%b q=%0d r=%0d dbz=%b, expected ov=1 q=3 r=0 dbz=0",
                     out_valid, quotient, remainder, div_by_zero);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        bit ok;
        do_op(8'd100, 8'd7, lat, ok);
        assert_count++;
        if (!ok) begin
            fail_count++;
            $display("[TB] FAIL hold_start: got out_valid=0, expected 1 within 40 cycles");
        end
        for (int c = 0; c < 20; c++) begin
            dividend = 8'(c * 13 + 1);
            divisor  = 8'd3;
            in_valid = 1'b1;
            @(posedge clk); #1;
            assert_count++;
            if ({out_valid, in_ready, quotient, remainder} !== {1'b1, 1'b0, 8'd14, 8'd2}) begin
                fail_count++;
                $display("[TB] FAIL hold_cycle%0d: got ov=%b ir=%b q=%0d r=%0d, expected ov=1 ir=0 q=14 r=2",
                         c, out_valid, in_ready, quotient, remainder);
            end
        end
        in_valid = 1'b0;
        release_result();
        assert_count++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fail_count++;
            $display("[TB] FAIL hold_release: got ov=%b ir=%b, expected ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int lat;
        out_ready = 1'b1;
        dividend  = 8'd120;
        divisor   = 8'd9;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        assert_count++;
        if (!out_valid || cyc != EXP_LAT || {quotient, remainder} !== {8'd13, 8'd3}) begin
            fail_count++;
            $display("[TB] FAIL b2b_first: got ov=%b cyc=%0d q=%0d r=%0d, expected ov=1 cyc=%0d q=13 r=3",
                     out_valid, cyc, quotient, remainder, EXP_LAT);
        end
        dividend = 8'd50;
        divisor  = 8'd6;
        in_valid = 1'b1;
        @(posedge clk); #1;
        cyc++;
        assert_count++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fail_count++;
            $display("[TB] FAIL b2b_idle: got ov=%b ir=%b, expected ov=0 ir=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        cyc++;
        in_valid = 1'b0;
        assert_count++;
        if (in_ready !== 1'b0 || cyc != EXP_LAT + 2) begin
            fail_count++;
            $display("[TB] FAIL b2b_accept: got ir=%b at cycle %0d, expected ir=0 at cycle %0d",
                     in_ready, cyc, EXP_LAT + 2);
        end
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        assert_count++;
        if (!out_valid || lat != EXP_LAT || {quotient, remainder} !== {8'd8, 8'd2}) begin
            fail_count++;
            $display("[TB] FAIL b2b_second: got ov=%b lat=%0d q=%0d r=%0d, expected ov=1 lat=%0d q=8 r=2",
                     out_valid, lat, quotient, remainder, EXP_LAT);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        bit ok;
        dividend = 8'd100;
        divisor  = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        assert_count++;
        if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL abort_reset: got ov=%b ir=%b q=%h r=%h dbz=%b, expected ov=0 ir=1 q=00 r=00 dbz=0",
                     out_valid, in_ready, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            assert_count++;
            if (out_valid !== 1'b0) begin
                fail_count++;
                $display("[TB] FAIL abort_stale_valid: got out_valid=%b, expected 0", out_valid);
            end
        end
        do_op(8'd9, 8'd3, lat, ok);
        assert_count++;
        if (!ok || lat != EXP_LAT || {quotient, remainder, div_by_zero} !== {8'd3, 8'd0, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL abort_followup: got ov=%b lat=%0d q=%0d r=%0d dbz=%b, expected ov=1 lat=%0d q=3 r=0 dbz=0",
                     ok, lat, quotient, remainder, div_by_zero, EXP_LAT);
        end
        release_result();
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        logic [7:0] vec [2][4];
        int lat;
        bit ok;
        vec[0] = '{8'hF9, 8'h02, 8'hFD, 8'hFF};
        vec[1] = '{8'h80, 8'hFF, 8'h80, 8'h00};
        for (int i = 0; i < 2; i++) begin
            do_op(vec[i][0], vec[i][1], lat, ok);
            assert_count++;
            if (!ok || lat != 10 || {quotient, remainder, div_by_zero} !== {vec[i][2], vec[i][3], 1'b0}) begin
                fail_count++;
                $display("[TB] FAIL signed %h/%h: got ov=%b lat=%0d q=%h r=%h dbz=%b, expected ov=1 lat=10 q=%h r=%h dbz=0",
                         vec[i][0], vec[i][1], ok, lat, quotient, remainder, div_by_zero, vec[i][2], vec[i][3]);
            end
            release_result();
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [16:0] exp;
        int lat;
        int exp_lat;
        bit ok;
        for (int i = 0; i < 500; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            case (i % 16)
                0: b = 8'h00;
                1: b = 8'hFF;
                2: a = 8'h80;
                3: a = 8'hFF;
                4: begin a = 8'h80; b = 8'hFF; end
                5: b = 8'h01;
                default: ;
            endcase
            exp     = model(a, b);
            exp_lat = (b == 8'h00) ? 1 : EXP_LAT;
            do_op(a, b, lat, ok);
            assert_count++;
            if (!ok || lat != exp_lat || {quotient, remainder, div_by_zero} !== exp) begin
                fail_count++;
                $display("[TB] FAIL random %h/%h: got ov=%b lat=%0d q=%h r=%h dbz=%b, expected ov=1 lat=%0d q=%h r=%h dbz=%b",
                         a, b, ok, lat, quotient, remainder, div_by_zero, exp_lat, exp[16:9], exp[8:1], exp[0]);
            end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
